// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding
// and frame timing constants.
package uart_pkg;

  // Transmitter FSM states; every state other than IDLE means a frame is on the line.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Default clk cycles per serial bit.
  localparam int CLKS_PER_BIT_DEFAULT = 156;

  // One frame is start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter. The search starts at the
// requester after last_grant and wraps, so the previous winner ranks last.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  // Walk the requesters from last_grant+1 upward; the first active one wins.
  always_comb begin : search
    logic           found;
    logic [IDW-1:0] cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDW'((int'(last_grant) + off) % NREQ);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Multi-requester UART transmitter. Requesters present a byte with
// req_valid; a round-robin winner is offered req_ready while the line is
// idle, and the accepted byte is sent as an 8N1 frame on txd.
//
// Handshake: a byte transfers on the rising clk edge where req_valid[i] and
// req_ready[i] are both high. req_ready is only ever offered in IDLE, to at
// most one requester, and never while nRST is low; req_valid may drop at any
// time before the transfer without consequence.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int NREQ         = 4
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*8-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    txd,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] gnt_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e      state, state_next;
  logic [CW-1:0]  clk_cnt, clk_cnt_next;
  logic [2:0]     bit_idx, bit_idx_next;
  logic [7:0]     shreg, shreg_next;
  logic           txd_q, txd_next;
  logic [IDW-1:0] last_grant, last_grant_next;
  logic [IDW-1:0] gnt_q, gnt_next;

  logic           arb_en;
  logic [IDW-1:0] win_idx;
  logic [7:0]     win_data;
  logic           handshake;

  // Only arbitrate while the line is free and reset is released.
  assign arb_en = (state == IDLE) && nRST;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req       (req_valid),
    .last_grant(last_grant),
    .en        (arb_en),
    .grant     (req_ready),
    .idx       (win_idx)
  );

  assign handshake = |(req_valid & req_ready);

  // Pick the winner's byte out of the flat data bus.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) win_data = req_data[i*8 +: 8];
    end
  end

  // Next-state, counters, shift register and registered txd value.
  always_comb begin
    state_next      = state;
    clk_cnt_next    = clk_cnt;
    bit_idx_next    = bit_idx;
    shreg_next      = shreg;
    txd_next        = txd_q;
    last_grant_next = last_grant;
    gnt_next        = gnt_q;
    case (state)
      IDLE: begin
        txd_next     = 1'b1;
        clk_cnt_next = '0;
        bit_idx_next = '0;
        if (handshake) begin
          state_next      = START;
          shreg_next      = win_data;
          last_grant_next = win_idx;
          gnt_next        = win_idx;
          txd_next        = 1'b0;
        end
      end
      START: begin
        if (clk_cnt == CNT_MAX) begin
          clk_cnt_next = '0;
          state_next   = DATA;
          txd_next     = shreg[0];
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_MAX) begin
          clk_cnt_next = '0;
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
            txd_next   = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            shreg_next   = {1'b0, shreg[7:1]};
            txd_next     = shreg[1];
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        txd_next = 1'b1;
        if (clk_cnt == CNT_MAX) begin
          clk_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  // State register; reset aborts any frame and parks the line high at once.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      txd_q      <= 1'b1;
      last_grant <= IDW'(NREQ - 1);
      gnt_q      <= '0;
    end else begin
      state      <= state_next;
      clk_cnt    <= clk_cnt_next;
      bit_idx    <= bit_idx_next;
      shreg      <= shreg_next;
      txd_q      <= txd_next;
      last_grant <= last_grant_next;
      gnt_q      <= gnt_next;
    end
  end

  assign txd    = txd_q;
  assign busy   = (state != IDLE);
  assign gnt_id = gnt_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with CLKS_PER_BIT=4, NREQ=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_scheduler;

  localparam int CPB  = 4;
  localparam int NREQ = 4;

  logic            clk;
  logic            nRST;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            txd;
  logic            busy;
  logic [1:0]      gnt_id;

  int tests;
  int fails;

  logic [0:0] exp_q[$];

  uart_tx_scheduler #(
    .CLKS_PER_BIT(CPB),
    .NREQ        (NREQ)
  ) dut (
    .clk      (clk),
    .nRST     (nRST),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .txd      (txd),
    .busy     (busy),
    .gnt_id   (gnt_id)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on the falling edge right after the accepting rising edge.
  // Checks every cycle of the frame against a start/data/stop bit queue.
  // chg_at: cycle at which requester 2's byte is zeroed and req_valid dropped.
  // stop_at: cycle at which to return early (frame left running).
  task automatic run_frame(input logic [7:0] b, input int id, input int chg_at, input int stop_at);
    logic [0:0] exp_bit;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
    exp_bit = 1'b0;
    for (int k = 1; k <= 10 * CPB; k++) begin
      if ((k - 1) % CPB == 0) exp_bit = exp_q.pop_front();
      check("frame_txd", 32'(txd), 32'(exp_bit));
      check("frame_busy", 32'(busy), 32'd1);
      check("frame_ready", 32'(req_ready), 32'd0);
      if (k == 1) check("frame_gnt_id", 32'(gnt_id), 32'(id));
      if (k == chg_at) begin
        req_data[23:16] = 8'h00;
        req_valid       = '0;
      end
      if (k == stop_at) return;
      @(negedge clk);
    end
    check("frame_end_busy", 32'(busy), 32'd0);
    check("frame_end_txd", 32'(txd), 32'd1);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    nRST      = 1'b0;
    req_valid = 4'hF;
    req_data  = '0;

    // Reset: all requesters valid, nothing offered, line idle.
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    req_valid = '0;
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd0);

    // Fairness: all valid, grants 0,1,2,3,0 spaced 41 cycles apart.
    req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    req_valid = 4'hF;
    #1;
    check("fair_first_ready", 32'(req_ready), 32'h1);
    for (int f = 0; f < 5; f++) begin
      @(negedge clk);
      if (f == 4) req_valid = '0;
      run_frame(8'h10 + 8'(f % 4) * 8'h11, f % 4, 0, 0);
      if (f < 4) check("fair_next_ready", 32'(req_ready), 32'(1 << ((f + 1) % 4)));
      else       check("fair_done_ready", 32'(req_ready), 32'd0);
    end

    // Single byte 8'hA5 from requester 2.
    req_data[23:16] = 8'hA5;
    req_valid       = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    run_frame(8'hA5, 2, 0, 0);
    check("single_after_ready", 32'(req_ready), 32'd0);

    // Mid-frame change: zero the byte and drop valid during DATA.
    req_valid = 4'b0100;
    #1;
    check("chg_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    run_frame(8'hA5, 2, 10, 0);
    check("chg_after_ready", 32'(req_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("chg_no_restart", 32'(busy), 32'd0);

    // Wrap: grant 3 first, then 4'b0011 gives 0 then 1.
    req_data[31:24] = 8'h5A;
    req_valid       = 4'b1000;
    #1;
    check("wrap_pre_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = 4'b0011;
    run_frame(8'h5A, 3, 0, 0);
    check("wrap_first_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    run_frame(8'h10, 0, 0, 0);
    check("wrap_second_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    run_frame(8'h21, 1, 0, 0);

    // Reset in the third data bit.
    req_data[23:16] = 8'hA5;
    req_valid       = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    run_frame(8'hA5, 2, 0, 14);
    nRST = 1'b0;
    #1;
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_gnt_id", 32'(gnt_id), 32'd0);
    req_valid = 4'b1001;
    #1;
    check("midrst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("midrst_hold_txd", 32'(txd), 32'd1);
    nRST = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    check("post_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    run_frame(8'h10, 0, 0, 0);
    check("post_rst_next_ready", 32'(req_ready), 32'h8);
    req_valid = '0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
